// File: rtl/fifo_mc_pkg.sv
// Shared constants and types for the multi-channel synchronous FIFO.
// Optional FIFO_FWFT_EN build macro is consumed by mc_sync_fifo.
package fifo_mc_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AF_LEVEL   = 56;
  localparam int DEF_AE_LEVEL   = 8;

  // Channel index width; a single-channel build still needs a 1-bit index.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_bits(DEF_NUM_CH);

  typedef logic [DEF_ADDR_WIDTH:0]   ptr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_ADDR_WIDTH:0]   count_t;

endpackage

// File: rtl/mc_fifo_ch_ctrl.sv
// Per-channel pointer, fill-level, threshold and sticky-error bookkeeping.
// Storage lives in the top level; this block only sees push/pop qualifiers.
module mc_fifo_ch_ctrl
  import fifo_mc_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  ovf_evt,
  input  logic                  udf_evt,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    wptr_d  = wptr_q + PW'(push);
    rptr_d  = rptr_q + PW'(pop);
    // Modulo subtraction on the wrap-extended pointers yields 0..DEPTH.
    count_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
              (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
    af_d    = (count_d >= PW'(AF_LEVEL));
    ae_d    = (count_d <= PW'(AE_LEVEL));
    // An error event in the same cycle as clr_err keeps the bit set.
    ovf_d   = ovf_evt | (ovf_q & ~clr_err);
    udf_d   = udf_evt | (udf_q & ~clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign waddr        = wptr_q[ADDR_WIDTH-1:0];
  assign raddr        = rptr_q[ADDR_WIDTH-1:0];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: rtl/mc_sync_fifo.sv
// Multi-channel single-clock FIFO: shared storage, channel decode, read mux/register.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module mc_sync_fifo
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ch_bits(NUM_CH)-1:0]     wr_ch,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [ch_bits(NUM_CH)-1:0]     rd_ch,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH-1:0]              empty,
  output logic [NUM_CH-1:0]              almost_full,
  output logic [NUM_CH-1:0]              almost_empty,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count,
  output logic [NUM_CH-1:0]              overflow,
  output logic [NUM_CH-1:0]              underflow,
  input  logic                           clr_err
);

  localparam int CH_BITS = ch_bits(NUM_CH);
  localparam int PW      = ADDR_WIDTH + 1;
  localparam int MEM_AW  = CH_BITS + ADDR_WIDTH;
  localparam int ROWS    = 1 << MEM_AW;

  logic [ADDR_WIDTH-1:0] waddr [NUM_CH];
  logic [ADDR_WIDTH-1:0] raddr [NUM_CH];
  logic [NUM_CH-1:0]     wr_sel, rd_sel, push, pop, ovf_evt, udf_evt;
  logic [MEM_AW-1:0]     wr_addr, rd_addr;
  logic                  any_push, any_pop;
  logic [DATA_WIDTH-1:0] rd_head;

  logic [DATA_WIDTH-1:0] mem [ROWS];

  // Indices >= NUM_CH match no channel, so such requests fall through untouched.
  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    push    = '0;
    pop     = '0;
    ovf_evt = '0;
    udf_evt = '0;
    wr_addr = '0;
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel[c]  = wr_en && (wr_ch == CH_BITS'(c));
      rd_sel[c]  = rd_en && (rd_ch == CH_BITS'(c));
      pop[c]     = rd_sel[c] && !empty[c];
      push[c]    = wr_sel[c] && (!full[c] || pop[c]);
      ovf_evt[c] = wr_sel[c] && full[c] && !pop[c];
      udf_evt[c] = rd_sel[c] && empty[c];
      if (wr_ch == CH_BITS'(c)) wr_addr = {wr_ch, waddr[c]};
      if (rd_ch == CH_BITS'(c)) rd_addr = {rd_ch, raddr[c]};
    end
  end

  assign any_push = |push;
  assign any_pop  = |pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    mc_fifo_ch_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
    ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .push         (push[g]),
      .pop          (pop[g]),
      .ovf_evt      (ovf_evt[g]),
      .udf_evt      (udf_evt[g]),
      .clr_err      (clr_err),
      .waddr        (waddr[g]),
      .raddr        (raddr[g]),
      .count        (count[g*PW +: PW]),
      .full         (full[g]),
      .empty        (empty[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .overflow     (overflow[g]),
      .underflow    (underflow[g])
    );
  end

  // NOTE: storage has no reset; occupancy comes from the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (any_push) mem[wr_addr] <= wr_data;
  end

  assign rd_head = mem[rd_addr];

`ifdef FIFO_FWFT_EN
  logic [NUM_CH-1:0] rd_match;

  always_comb begin
    rd_match = '0;
    for (int c = 0; c < NUM_CH; c++) rd_match[c] = (rd_ch == CH_BITS'(c));
  end

  assign rd_data  = rd_head;
  assign rd_valid = |(rd_match & ~empty);
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = any_pop ? rd_head : rd_data_q;
    rd_valid_d = any_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_mc_sync_fifo.sv
// Directed self-checking bench for mc_sync_fifo in its default registered-read build.
module tb_mc_sync_fifo;
  import fifo_mc_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int NCH = 4;
  localparam int PW  = AW + 1;

  logic              clk, rst;
  logic              wr_en, rd_en, clr_err;
  logic [1:0]        wr_ch, rd_ch;
  logic [DW-1:0]     wr_data, rd_data;
  logic              rd_valid;
  logic [NCH-1:0]    full, empty, almost_full, almost_empty, overflow, underflow;
  logic [NCH*PW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  mc_sync_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_CH     (NCH),
    .AF_LEVEL   (56),
    .AE_LEVEL   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return 32'(count[ch*PW +: PW]);
  endfunction

  task automatic cycle(input logic we, input logic [1:0] wc, input logic [7:0] wd,
                       input logic re, input logic [1:0] rc, input logic clr);
    wr_en   = we;
    wr_ch   = wc;
    wr_data = wd;
    rd_en   = re;
    rd_ch   = rc;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] d);
    cycle(1'b1, ch, d, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic pop(input logic [1:0] ch);
    cycle(1'b0, 2'd0, 8'h00, 1'b1, ch, 1'b0);
  endtask

  function automatic logic [7:0] wv(input int i);
    return 8'((i * 37 + 5) & 8'hFF);
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    wr_ch = '0; rd_ch = '0; wr_data = '0;
    #12;
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("init_empty", 32'(empty), 32'hF);
    check("init_full", 32'(full), 32'h0);
    check("init_ae", 32'(almost_empty), 32'hF);
    check("init_af", 32'(almost_full), 32'h0);
    check("init_count", 32'(count), 32'h0);
    check("init_ovf", 32'(overflow), 32'h0);
    check("init_udf", 32'(underflow), 32'h0);
    check("init_rd_data", 32'(rd_data), 32'h0);

    // 1: fill ch2, drain in order
    for (int i = 0; i < 64; i++) push(2'd2, 8'(i));
    check("t1_count2", cnt(2), 32'd64);
    check("t1_full", 32'(full), 32'h4);
    check("t1_empty", 32'(empty), 32'hB);
    check("t1_af", 32'(almost_full), 32'h4);
    check("t1_ae", 32'(almost_empty), 32'hB);
    pop(2'd2);
    check("t1_rd_valid", 32'(rd_valid), 32'h1);
    check("t1_rd_data0", 32'(rd_data), 32'h00);
    check("t1_full_drop", 32'(full), 32'h0);
    check("t1_count63", cnt(2), 32'd63);
    pop(2'd2);
    check("t1_rd_data1", 32'(rd_data), 32'h01);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("t1_valid_low", 32'(rd_valid), 32'h0);
    check("t1_data_hold", 32'(rd_data), 32'h01);
    for (int i = 2; i < 64; i++) begin
      pop(2'd2);
      check("t1_drain", 32'(rd_data), 32'(i));
    end
    check("t1_empty_end", 32'(empty), 32'hF);

    // 2: overflow, clear, clear-vs-event, simultaneous rd/wr when full
    for (int i = 0; i < 64; i++) push(2'd1, 8'(8'h80 + i));
    push(2'd1, 8'hAA);
    check("t2_ovf", 32'(overflow), 32'h2);
    check("t2_count64", cnt(1), 32'd64);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    check("t2_ovf_clr", 32'(overflow), 32'h0);
    cycle(1'b1, 2'd1, 8'hCC, 1'b0, 2'd0, 1'b1);
    check("t2_ovf_wins", 32'(overflow), 32'h2);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    check("t2_ovf_clr2", 32'(overflow), 32'h0);
    cycle(1'b1, 2'd1, 8'hBB, 1'b1, 2'd1, 1'b0);
    check("t2_rw_valid", 32'(rd_valid), 32'h1);
    check("t2_rw_data", 32'(rd_data), 32'h80);
    check("t2_rw_count", cnt(1), 32'd64);
    check("t2_rw_full", 32'(full), 32'h2);
    check("t2_rw_noovf", 32'(overflow), 32'h0);
    for (int i = 1; i < 64; i++) begin
      pop(2'd1);
      check("t2_drain", 32'(rd_data), 32'(8'h80 + i));
    end
    pop(2'd1);
    check("t2_last", 32'(rd_data), 32'hBB);
    check("t2_empty", 32'(empty), 32'hF);

    // 3: read of empty ch3 with same-cycle write is not bypassed
    cycle(1'b1, 2'd3, 8'h55, 1'b1, 2'd3, 1'b0);
    check("t3_udf", 32'(underflow), 32'h8);
    check("t3_rd_valid", 32'(rd_valid), 32'h0);
    check("t3_count1", cnt(3), 32'd1);
    check("t3_data_hold", 32'(rd_data), 32'hBB);
    pop(2'd3);
    check("t3_valid", 32'(rd_valid), 32'h1);
    check("t3_data", 32'(rd_data), 32'h55);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    check("t3_udf_clr", 32'(underflow), 32'h0);

    // 4: interleaved channels stay isolated
    push(2'd0, 8'h10);
    push(2'd1, 8'h20);
    push(2'd0, 8'h11);
    push(2'd1, 8'h21);
    check("t4_count0", cnt(0), 32'd2);
    check("t4_count1", cnt(1), 32'd2);
    pop(2'd0);
    check("t4_c0a", 32'(rd_data), 32'h10);
    pop(2'd1);
    check("t4_c1a", 32'(rd_data), 32'h20);
    pop(2'd0);
    check("t4_c0b", 32'(rd_data), 32'h11);
    pop(2'd1);
    check("t4_c1b", 32'(rd_data), 32'h21);
    check("t4_empty", 32'(empty), 32'hF);

    // 5: thresholds on ch0
    for (int i = 0; i < 55; i++) begin
      push(2'd0, 8'(i));
      if (i == 7) check("t5_ae_at8", 32'(almost_empty[0]), 32'h1);
      if (i == 8) check("t5_ae_at9", 32'(almost_empty[0]), 32'h0);
    end
    check("t5_count55", cnt(0), 32'd55);
    check("t5_af_at55", 32'(almost_full[0]), 32'h0);
    push(2'd0, 8'd55);
    check("t5_af_at56", 32'(almost_full[0]), 32'h1);
    check("t5_count56", cnt(0), 32'd56);
    for (int i = 0; i < 48; i++) begin
      pop(2'd0);
      check("t5_drain", 32'(rd_data), 32'(i));
      if (i == 46) check("t5_ae_at9d", 32'(almost_empty[0]), 32'h0);
    end
    check("t5_count8", cnt(0), 32'd8);
    check("t5_ae_at8d", 32'(almost_empty[0]), 32'h1);
    check("t5_af_off", 32'(almost_full[0]), 32'h0);

    // 6: asynchronous reset mid-burst, then pointer wrap
    for (int i = 0; i < 30; i++) push(2'd2, 8'(8'h40 + i));
    check("t6_count30", cnt(2), 32'd30);
    rd_en = 1'b1;
    rd_ch = 2'd2;
    @(posedge clk);
    #2;
    check("t6_pre_valid", 32'(rd_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_empty", 32'(empty), 32'hF);
    check("t6_rst_count", 32'(count), 32'h0);
    check("t6_rst_valid", 32'(rd_valid), 32'h0);
    check("t6_rst_data", 32'(rd_data), 32'h0);
    check("t6_rst_full", 32'(full), 32'h0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(2'd2, wv(0));
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 2'd2, wv(i + 1), 1'b1, 2'd2, 1'b0);
      check("t6_wrap", 32'(rd_data), 32'(wv(i)));
    end
    check("t6_wrap_count", cnt(2), 32'd1);
    pop(2'd2);
    check("t6_wrap_last", 32'(rd_data), 32'(wv(200)));
    check("t6_wrap_empty", 32'(empty), 32'hF);
    check("t6_no_err", 32'({overflow, underflow}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
